rotate_right_seq_32_bit: RTL and testbench
==========================================

// Module: rotate_right_seq_32_bit
// PURPOSE
//   Multi-cycle 32-bit rotate-right unit for the ALU (ROR). It is the counterpart of the
//   combinational rotate-left block. Uses a start/busy/done handshake.
//   Each clock rotates by up to STEP bit positions, which trades latency for area.
//   Sits beside the other ALU shifters; the control unit waits on done before latching out into Z.
// PARAMETERS
//   WIDTH    32  data width; the only supported value is 32.
//   SHAMT_W  5   rotate-amount width, equal to log2(WIDTH).
//   STEP     1   maximum bit positions rotated per cycle. Legal values: 1, 2, 4, 8, 16.
// PORTS
//   clk    in   1        rising-edge clock.
//   clr    in   1        asynchronous, active-low reset.
//   start  in   1        request pulse. Sampled only in IDLE or DONE.
//   in     in   WIDTH    operand. Captured on the accepted start edge.
//   b      in   SHAMT_W  rotate amount, 0..31. Captured on the accepted start edge.
//   out    out  WIDTH    result register. Holds the last result until the next DONE.
//   busy   out  1        high while the operation is accepted and not yet done.
//   done   out  1        single-cycle pulse; out is valid in this cycle.
// BEHAVIOUR
//   Reset (clr=0, async): state=IDLE, out=0, busy=0, done=0, internal acc=0, rem=0.
//     Reset overrides everything. Deasserting reset mid-operation leaves the block in IDLE.
//     The aborted operation is lost and no done is produced for it.
//   States: IDLE, BUSY, DONE. All outputs are registered.
//   IDLE:
//     start=1 at an edge: acc<=in, rem<=b.
//     If b==0, go to DONE with out<=in; otherwise go to BUSY.
//     start=0: stay in IDLE.
//   BUSY:
//     On each edge, s=min(rem,STEP); acc<=rotr(acc,s); rem<=rem-s.
//     When rem-s==0: out<=rotr(acc,s) and go to DONE.
//     start is ignored while BUSY; in and b changing during BUSY have no effect.
//   DONE: done=1 for exactly one cycle.
//     start=1: accepted exactly as in IDLE (back-to-back operation, no idle bubble).
//     start=0: go to IDLE.
//   busy=1 in BUSY only. done=1 in DONE only. busy and done are never high together.
//   Latency: with start accepted at edge k and n=ceil(b/STEP), done is high in the
//     cycle after edge k+n. For b=0, done is high in the cycle after edge k.
//   rotr(x,s)={x[s-1:0],x[31:s]}. It is lossless (no bits dropped) and wraps modulo 32.
//   The result must equal rotl(in,(32-b) mod 32) from the rotate-left block.
//   out changes only on entry to DONE or on reset. It is stable in IDLE and BUSY.
// TESTING
//   1. Reset: hold clr=0 with start=1 -> out=0, busy=0, done=0. Release: IDLE, no done pulse.
//   2. STEP=1, in=0x80000001, b=1 -> done 1 cycle after accept, out=0xC0000000.
//      Then b=31, in=0x00000001 -> done 31 cycles after accept, out=0x00000002.
//   3. STEP=4, in=0x12345678, b=8 -> done 2 cycles after accept, out=0x78123456.
//      Then b=5 -> 2 cycles, out=0xC091A2B3.
//   4. b=0, in=0xDEADBEEF -> done in the cycle after accept, out=0xDEADBEEF, busy never high.
//   5. Start pulsed again mid-BUSY with new in/b -> ignored; first result correct.
//      Start held high in DONE -> second operation accepted with no IDLE cycle.
//   6. clr pulsed low mid-BUSY -> out=0, IDLE, no done. Random in/b (1k vectors, STEP=1/4/16)
//      -> out==rotl(in,(32-b)%32) and latency==ceil(b/STEP).

Source files
------------

// File: rtl/rotate_right_seq_32_bit.sv
// rotate_right_seq_32_bit: multi-cycle 32-bit rotate-right, up to STEP bits per clock,
// with a start/busy/done handshake.
module rotate_right_seq_32_bit #(
    parameter int WIDTH   = 32,
    parameter int SHAMT_W = 5,
    parameter int STEP    = 1
) (
    input  logic               clk,
    input  logic               clr,
    input  logic               start,
    input  logic [WIDTH-1:0]   in,
    input  logic [SHAMT_W-1:0] b,
    output logic [WIDTH-1:0]   out,
    output logic               busy,
    output logic               done
);
    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;
    state_t state, state_nx;
    logic [WIDTH-1:0] acc, rot;
    logic [SHAMT_W-1:0] rem, s, rem_nx;
    logic accept;
    always_comb begin
        accept = start && state != BUSY;
        s = (rem < SHAMT_W'(STEP)) ? rem : SHAMT_W'(STEP);
        // doubling the word turns a right shift into a lossless rotate
        rot = WIDTH'({acc, acc} >> s);
        rem_nx = rem - s;
        state_nx = accept ? (b == '0 ? DONE : BUSY) :
                   state == BUSY ? (rem_nx == '0 ? DONE : BUSY) : IDLE;
    end
    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            state <= IDLE;
            acc   <= '0;
            rem   <= '0;
            out   <= '0;
            busy  <= 1'b0;
            done  <= 1'b0;
        end else begin
            state <= state_nx;
            busy  <= state_nx == BUSY;
            done  <= state_nx == DONE;
            if (accept) begin
                acc <= in;
                rem <= b;
                if (b == '0) out <= in;
            end else if (state == BUSY) begin
                acc <= rot;
                rem <= rem_nx;
                if (rem_nx == '0) out <= rot;
            end
        end
    end
endmodule

// File: tb/tb_rotate_right_seq_32_bit.sv
// tb_rotate_right_seq_32_bit: drives STEP=1/4/16 instances in parallel and compares
// against a rotate-left reference model and ceil(b/STEP) latency.
module tb_rotate_right_seq_32_bit;
    logic clk = 0, clr = 0, start = 0;
    logic [31:0] in = '0;
    logic [4:0] b = '0;
    logic [31:0] o [3];
    logic bz [3], dn [3];
    int checks = 0, passed = 0;
    localparam int STEPS [3] = '{1, 4, 16};

    always #5 clk = ~clk;

    rotate_right_seq_32_bit #(.STEP(1)) d1 (.clk(clk), .clr(clr), .start(start), .in(in), .b(b), .out(o[0]), .busy(bz[0]), .done(dn[0]));
    rotate_right_seq_32_bit #(.STEP(4)) d4 (.clk(clk), .clr(clr), .start(start), .in(in), .b(b), .out(o[1]), .busy(bz[1]), .done(dn[1]));
    rotate_right_seq_32_bit #(.STEP(16)) d16 (.clk(clk), .clr(clr), .start(start), .in(in), .b(b), .out(o[2]), .busy(bz[2]), .done(dn[2]));

    typedef struct {
        logic [31:0] in;
        logic [4:0]  b;
        logic [31:0] exp;
        int          lat [3];
    } vec_t;

    function automatic logic [31:0] rotl(logic [31:0] x, int n);
        return n == 0 ? x : (x << n) | (x >> (32 - n));
    endfunction

    function automatic int ceil_div(int x, int y);
        return (x + y - 1) / y;
    endfunction

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    // Issue one op to all instances; check result, latency, out stability and busy/done exclusion.
    task automatic run_op(logic [31:0] x, logic [4:0] amt, logic [31:0] exp, int l0, int l1, int l2);
        int lat [3];
        int got [3];
        logic [31:0] res [3], prev [3];
        logic stable [3], seen_busy [3], overlap;
        lat = '{l0, l1, l2};
        overlap = 0;
        for (int i = 0; i < 3; i++) begin
            got[i] = -1; res[i] = '0; prev[i] = o[i]; stable[i] = 1; seen_busy[i] = 0;
        end
        @(negedge clk);
        start = 1; in = x; b = amt;
        @(posedge clk);
        for (int m = 0; m < 40; m++) begin
            @(negedge clk);
            start = 0;
            in = $urandom; b = 5'($urandom);
            for (int i = 0; i < 3; i++) begin
                if (bz[i] && dn[i]) overlap = 1;
                if (got[i] < 0) begin
                    if (bz[i]) seen_busy[i] = 1;
                    if (dn[i]) begin got[i] = m; res[i] = o[i]; end
                    else if (o[i] !== prev[i]) stable[i] = 0;
                end
            end
            if (got[0] >= 0 && got[1] >= 0 && got[2] >= 0) break;
        end
        for (int i = 0; i < 3; i++) begin
            chk($sformatf("out step%0d in=%h b=%0d", STEPS[i], x, amt), res[i], exp);
            chk($sformatf("latency step%0d b=%0d", STEPS[i], amt), 32'(got[i]), 32'(lat[i]));
            chk($sformatf("out_stable step%0d", STEPS[i]), 32'(stable[i]), 32'd1);
            if (amt == 0) chk($sformatf("busy_seen b=0 step%0d", STEPS[i]), 32'(seen_busy[i]), 32'd0);
        end
        chk("busy_and_done", 32'(overlap), 32'd0);
    endtask

    task automatic idle_cycles(int n);
        start = 0;
        repeat (n) @(negedge clk);
    endtask

    initial begin
        vec_t tbl [5];
        int m, lat;
        logic [31:0] exp, ra, rb;
        int ndone;
        tbl[0] = '{32'h80000001, 5'd1,  32'hC0000000, '{1, 1, 1}};
        tbl[1] = '{32'h00000001, 5'd31, 32'h00000002, '{31, 8, 2}};
        tbl[2] = '{32'h12345678, 5'd8,  32'h78123456, '{8, 2, 1}};
        tbl[3] = '{32'h12345678, 5'd5,  32'hC091A2B3, '{5, 2, 1}};
        tbl[4] = '{32'hDEADBEEF, 5'd0,  32'hDEADBEEF, '{0, 0, 0}};

        // reset held with start asserted
        start = 1; in = 32'hFFFFFFFF; b = 5'd3;
        repeat (3) @(negedge clk);
        for (int i = 0; i < 3; i++)
            chk($sformatf("reset out/busy/done step%0d", STEPS[i]), {o[i][29:0], bz[i], dn[i]}, 32'd0);
        start = 0;
        clr = 1;
        ndone = 0;
        repeat (4) begin
            @(negedge clk);
            for (int i = 0; i < 3; i++) ndone += int'(dn[i]) + int'(bz[i]);
        end
        chk("no activity after reset release", 32'(ndone), 32'd0);

        foreach (tbl[k]) run_op(tbl[k].in, tbl[k].b, tbl[k].exp, tbl[k].lat[0], tbl[k].lat[1], tbl[k].lat[2]);

        // start pulsed mid-BUSY on the STEP=1 instance is ignored
        idle_cycles(2);
        start = 1; in = 32'hA5A5A5A5; b = 5'd20;
        @(posedge clk);
        @(negedge clk); start = 0;
        repeat (3) @(negedge clk);
        start = 1; in = 32'hFFFF0000; b = 5'd3;
        @(negedge clk); start = 0;
        m = 4;
        while (!dn[0] && m < 40) begin @(negedge clk); m++; end
        chk("ignored start latency", 32'(m), 32'd20);
        chk("ignored start out", o[0], rotl(32'hA5A5A5A5, 12));

        // back-to-back: start held through DONE, second op accepted with no IDLE cycle
        idle_cycles(40);
        ra = 32'h0F0F1234; rb = 32'h13579BDF;
        start = 1; in = ra; b = 5'd2;
        @(posedge clk);
        m = 0;
        @(negedge clk);
        while (!dn[0] && m < 40) begin @(negedge clk); m++; end
        chk("b2b first latency", 32'(m), 32'd2);
        chk("b2b first out", o[0], rotl(ra, 30));
        in = rb; b = 5'd3;
        @(negedge clk); start = 0;
        chk("b2b no idle bubble", 32'(bz[0]), 32'd1);
        m = 0;
        while (!dn[0] && m < 40) begin @(negedge clk); m++; end
        chk("b2b second latency", 32'(m), 32'd3);
        chk("b2b second out", o[0], rotl(rb, 29));

        // reset mid-BUSY aborts with no done
        idle_cycles(40);
        start = 1; in = 32'hCAFEF00D; b = 5'd20;
        @(negedge clk); start = 0;
        repeat (4) @(negedge clk);
        clr = 0;
        #1;
        chk("abort out", o[0], 32'd0);
        chk("abort busy/done", {30'd0, bz[0], dn[0]}, 32'd0);
        @(negedge clk);
        clr = 1;
        ndone = 0;
        repeat (25) begin @(negedge clk); ndone += int'(dn[0]) + int'(bz[0]); end
        chk("abort no done", 32'(ndone), 32'd0);

        // random vectors against the rotate-left model
        for (int v = 0; v < 1000; v++) begin
            logic [31:0] x;
            logic [4:0] amt;
            x = $urandom;
            amt = 5'($urandom);
            if (v < 8) amt = (v % 2 == 0) ? 5'd0 : 5'd31;
            exp = rotl(x, (32 - int'(amt)) % 32);
            run_op(x, amt, exp, ceil_div(amt, 1), ceil_div(amt, 4), ceil_div(amt, 16));
        end

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end
endmodule
